// File: rtl/kernel_out_sink_pkg.sv
// Shared definitions for the kernel output sink: run FSM encoding, the
// result word width and a ceiling-log2 helper used to size pointers.
package kernel_out_sink_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } sink_state_e;

   // ceil(log2(value)); 0 for value <= 1
   function automatic int clog2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/kernel_out_sink_fifo.sv
// out_sink_fifo: first-word-fall-through synchronous FIFO with occupancy
// count, full and empty. DEPTH must be a power of two so the pointers wrap
// by natural overflow. Full/empty come from registered count only, so a
// pop never makes room for a push in the same cycle.
module out_sink_fifo
   import kernel_out_sink_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [clog2(DEPTH):0] count,
   output logic                  full,
   output logic                  empty
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // next pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // pointer/count state, cleared asynchronously so buffered words vanish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage; contents are meaningless until pointed at by a valid count
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/kernel_out_sink.sv
// kernel_out_sink: absorbs ap_fifo-style kernel results into a small FIFO,
// drains one word every DRAIN_INV cycles, folds each word to a nibble and
// tracks per-run word count, error flag and (optionally) a checksum.
// Optional feature macro: OUT_SINK_CHECKSUM_EN builds the rotate-xor
// checksum register; without it checksum reads 0.
module kernel_out_sink #(
   parameter int DATA_WIDTH     = kernel_out_sink_pkg::DATA_WIDTH,
   parameter int FIFO_DEPTH     = 4,
   parameter int DRAIN_INV      = 1,
   parameter int EXPECTED_WORDS = 64
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ap_start,
   input  logic                  ap_done,
   input  logic [DATA_WIDTH-1:0] s_din,
   input  logic                  s_write,
   output logic                  s_full_n,
   output logic [3:0]            data_out,
   output logic                  data_valid,
   output logic [15:0]           word_cnt,
   output logic [31:0]           checksum,
   output logic                  run_err
);

   import kernel_out_sink_pkg::*;

   localparam int PTR_W     = clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int DRN_W     = (clog2(DRAIN_INV) < 1) ? 1 : clog2(DRAIN_INV);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_INV - 1);

   sink_state_e           state_q, state_d;
   logic                  start_q;
   logic [DRN_W-1:0]      drain_q, drain_d;
   logic [3:0]            data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d;
   logic [15:0]           word_cnt_q, word_cnt_d;
   logic                  run_err_q, run_err_d;

   logic [DATA_WIDTH-1:0] fifo_dout;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_full, fifo_empty;
   logic                  accepting, push, pop, start_rise;
   logic                  write_err, start_err, done_err, run_clear;
   logic [7:0]            x8;
   logic [3:0]            nibble;

   assign start_rise = ap_start & ~start_q;
   assign accepting  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign s_full_n   = (fifo_count < CNT_W'(FIFO_DEPTH));
   assign push       = s_write & s_full_n & accepting;
   assign pop        = ~fifo_empty & (drain_q == DRN_LAST);
   // dropped words: FIFO full, or no run in progress
   assign write_err  = s_write & (fifo_full | ~accepting);

   out_sink_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (ap_clk),
      .rst   (ap_rst),
      .push  (push),
      .pop   (pop),
      .din   (s_din),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // run FSM: next state plus the per-run clear and error events
   always_comb begin
      state_d   = state_q;
      run_clear = 1'b0;
      start_err = 1'b0;
      done_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               state_d   = ST_RUN;
               run_clear = 1'b1;
            end
         end
         ST_RUN: begin
            start_err = start_rise;
            if (ap_done) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            start_err = start_rise;
            // empty means no pop this cycle, so word_cnt_q is final here
            if (fifo_empty) begin
               state_d  = ST_DONE;
               done_err = (word_cnt_q != 16'(EXPECTED_WORDS));
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // drain pacing, fold, word count and sticky error
   always_comb begin
      drain_d      = (drain_q == DRN_LAST) ? '0 : drain_q + DRN_W'(1);
      x8           = fifo_dout[7:0] ^ fifo_dout[15:8] ^ fifo_dout[23:16] ^ fifo_dout[31:24];
      nibble       = x8[7:4] ^ x8[3:0];
      data_out_d   = pop ? nibble : 4'h0;
      data_valid_d = pop;
      word_cnt_d   = word_cnt_q;
      if (run_clear)
         word_cnt_d = '0;
      else if (pop && (word_cnt_q != 16'hFFFF))
         word_cnt_d = word_cnt_q + 16'd1;
      run_err_d = run_clear ? 1'b0 : run_err_q;
      if (write_err || start_err || done_err) run_err_d = 1'b1;
   end

   // control and output registers
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q      <= ST_IDLE;
         start_q      <= 1'b0;
         drain_q      <= '0;
         data_out_q   <= 4'h0;
         data_valid_q <= 1'b0;
         word_cnt_q   <= '0;
         run_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= ap_start;
         drain_q      <= drain_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         word_cnt_q   <= word_cnt_d;
         run_err_q    <= run_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign word_cnt   = word_cnt_q;
   assign run_err    = run_err_q;

`ifdef OUT_SINK_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   // order-sensitive checksum: rotate left by one, then xor the popped word
   always_comb begin
      checksum_d = checksum_q;
      if (run_clear)
         checksum_d = '0;
      else if (pop)
         checksum_d = {checksum_q[30:0], checksum_q[31]} ^ fifo_dout;
   end

   // checksum register
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) checksum_q <= '0;
      else        checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_kernel_out_sink.sv
// Directed bench for kernel_out_sink: a DRAIN_INV=1 instance (latency, fold,
// run accounting, errors) and a DRAIN_INV=4 instance (back-pressure, reset
// mid-run). Inputs change 1 time unit after the rising edge and outputs are
// sampled at that same point, when registered values are settled.
module tb_kernel_out_sink;
   import kernel_out_sink_pkg::*;

   localparam logic [31:0] CK1 =
`ifdef OUT_SINK_CHECKSUM_EN
      32'h12345678;
`else
      32'h0;
`endif
   localparam logic [31:0] CK2 =
`ifdef OUT_SINK_CHECKSUM_EN
      32'hDB97530F;
`else
      32'h0;
`endif

   logic        ap_clk, ap_rst;
   logic        a_start, a_done, a_write, a_full_n, a_valid, a_err;
   logic [31:0] a_din, a_cks;
   logic [3:0]  a_dout;
   logic [15:0] a_cnt;
   logic        b_start, b_done, b_write, b_full_n, b_valid, b_err;
   logic [31:0] b_din, b_cks;
   logic [3:0]  b_dout;
   logic [15:0] b_cnt;

   int checks = 0;
   int passes = 0;

   kernel_out_sink #(.FIFO_DEPTH(4), .DRAIN_INV(1), .EXPECTED_WORDS(64)) dut_a (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(a_start), .ap_done(a_done),
      .s_din(a_din), .s_write(a_write), .s_full_n(a_full_n), .data_out(a_dout),
      .data_valid(a_valid), .word_cnt(a_cnt), .checksum(a_cks), .run_err(a_err));

   kernel_out_sink #(.FIFO_DEPTH(4), .DRAIN_INV(4), .EXPECTED_WORDS(64)) dut_b (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(b_start), .ap_done(b_done),
      .s_din(b_din), .s_write(b_write), .s_full_n(b_full_n), .data_out(b_dout),
      .data_valid(b_valid), .word_cnt(b_cnt), .checksum(b_cks), .run_err(b_err));

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_start = 0; a_done = 0; a_write = 0; a_din = '0;
      b_start = 0; b_done = 0; b_write = 0; b_din = '0;
   endtask

   // leaves reset released just after an edge, so both drain counters read 0
   task automatic do_reset();
      idle_inputs();
      ap_rst = 1'b1;
      step();
      step();
      ap_rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      ap_rst = 1'b1;
      #1;
      checks++; if (a_full_n !== 1'b1) $display("FAIL rst_full_n: got %b want 1", a_full_n); else passes++;
      checks++; if (a_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", a_valid); else passes++;
      checks++; if (a_dout !== 4'h0) $display("FAIL rst_dout: got %h want 0", a_dout); else passes++;
      checks++; if (a_cnt !== 16'h0) $display("FAIL rst_cnt: got %h want 0", a_cnt); else passes++;
      checks++; if (a_cks !== 32'h0) $display("FAIL rst_cks: got %h want 0", a_cks); else passes++;
      checks++; if (a_err !== 1'b0) $display("FAIL rst_err: got %b want 0", a_err); else passes++;
      checks++; if (b_full_n !== 1'b1) $display("FAIL rst_b_full_n: got %b want 1", b_full_n); else passes++;
      step();
      step();
      ap_rst = 1'b0;
   endtask

   task automatic test_latency();
      do_reset();
      a_start = 1; step(); a_start = 0;
      a_write = 1; a_din = 32'h12345678; step();   // cycle N
      a_write = 0;
      checks++; if (a_valid !== 1'b0) $display("FAIL lat_early: valid got %b want 0 at N+1", a_valid); else passes++;
      step();                                       // cycle N+2
      checks++; if (a_valid !== 1'b1) $display("FAIL lat_valid: got %b want 1 at N+2", a_valid); else passes++;
      checks++; if (a_dout !== 4'h8) $display("FAIL lat_dout: got %h want 8", a_dout); else passes++;
      checks++; if (a_cks !== CK1) $display("FAIL lat_cks: got %h want %h", a_cks, CK1); else passes++;
      checks++; if (a_cnt !== 16'd1) $display("FAIL lat_cnt: got %0d want 1", a_cnt); else passes++;
      step();
      checks++; if (a_valid !== 1'b0 || a_dout !== 4'h0) $display("FAIL lat_idle: valid %b dout %h want 0/0", a_valid, a_dout); else passes++;
   endtask

   task automatic test_two_words();
      do_reset();
      a_start = 1; step(); a_start = 0;
      a_write = 1; a_din = 32'h12345678; step();
      a_din = 32'hFFFFFFFF; step();
      a_write = 0;
      checks++; if (a_valid !== 1'b1 || a_dout !== 4'h8) $display("FAIL two_first: valid %b dout %h want 1/8", a_valid, a_dout); else passes++;
      step();
      checks++; if (a_valid !== 1'b1 || a_dout !== 4'h0) $display("FAIL two_second: valid %b dout %h want 1/0", a_valid, a_dout); else passes++;
      checks++; if (a_cnt !== 16'd2) $display("FAIL two_cnt: got %0d want 2", a_cnt); else passes++;
      checks++; if (a_cks !== CK2) $display("FAIL two_cks: got %h want %h", a_cks, CK2); else passes++;
   endtask

   task automatic test_run(input int n, input logic exp_err);
      bit reached;
      do_reset();
      a_start = 1; step(); a_start = 0;
      for (int i = 0; i < n; i++) begin
         a_write = 1; a_din = 32'(i) * 32'h01010101; step();
      end
      a_write = 0;
      a_done = 1; step(); a_done = 0;
      reached = 0;
      for (int k = 0; k < 20 && !reached; k++) begin
         if (dut_a.state_q == ST_DONE) reached = 1;
         else step();
      end
      checks++; if (!reached) $display("FAIL run%0d_done: DONE not reached within 20 cycles", n); else passes++;
      checks++; if (a_err !== exp_err) $display("FAIL run%0d_err: got %b want %b", n, a_err, exp_err); else passes++;
      checks++; if (a_cnt !== 16'(n)) $display("FAIL run%0d_cnt: got %0d want %0d", n, a_cnt, n); else passes++;
      step();
      // a fresh start edge in IDLE clears the previous run's status
      a_start = 1; step(); a_start = 0;
      checks++; if (a_err !== 1'b0 || a_cnt !== 16'd0) $display("FAIL run%0d_restart: err %b cnt %0d want 0/0", n, a_err, a_cnt); else passes++;
   endtask

   task automatic test_errors();
      do_reset();
      a_write = 1; a_din = 32'hDEAD0001; step(); a_write = 0;
      checks++; if (a_err !== 1'b1) $display("FAIL err_idle_write: got %b want 1", a_err); else passes++;
      checks++; if (a_valid !== 1'b0) $display("FAIL err_idle_drop: valid got %b want 0", a_valid); else passes++;
      a_start = 1; step();
      checks++; if (a_err !== 1'b0) $display("FAIL err_start_clear: got %b want 0", a_err); else passes++;
      a_start = 0; step();
      a_start = 1; step(); a_start = 0;
      checks++; if (a_err !== 1'b1) $display("FAIL err_start_in_run: got %b want 1", a_err); else passes++;
   endtask

   task automatic test_back_to_back_full();
      do_reset();
      b_start = 1; step(); b_start = 0;   // drain 1
      step();                             // drain 2
      step();                             // drain 3: FIFO empty, no pop
      for (int i = 0; i < 4; i++) begin
         checks++; if (b_full_n !== 1'b1) $display("FAIL full_open%0d: s_full_n got %b want 1", i, b_full_n); else passes++;
         b_write = 1; b_din = 32'h100 + 32'(i); step();
      end
      checks++; if (b_full_n !== 1'b0) $display("FAIL full_after4: s_full_n got %b want 0", b_full_n); else passes++;
      checks++; if (b_err !== 1'b0) $display("FAIL full_noerr: run_err got %b want 0", b_err); else passes++;
      b_din = 32'h200; step(); b_write = 0;
      checks++; if (b_err !== 1'b1) $display("FAIL full_overflow: run_err got %b want 1", b_err); else passes++;
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      do_reset();
      b_start = 1; step(); b_start = 0;
      for (int i = 0; i < 3; i++) begin
         b_write = 1; b_din = 32'h0F0F0000 + 32'(i); step();
      end
      b_write = 0;
      ap_rst = 1'b1;
      #1;
      checks++; if (b_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", b_valid); else passes++;
      checks++; if (b_full_n !== 1'b1) $display("FAIL mid_full_n: got %b want 1", b_full_n); else passes++;
      checks++; if (b_cnt !== 16'd0 || b_err !== 1'b0 || b_cks !== 32'h0) $display("FAIL mid_clear: cnt %0d err %b cks %h want 0", b_cnt, b_err, b_cks); else passes++;
      step();
      ap_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (b_valid !== 1'b0) $display("FAIL mid_quiet%0d: valid got %b want 0", i, b_valid); else passes++;
      end
      b_start = 1; step(); b_start = 0;
      b_write = 1; b_din = 32'h000000A5; step(); b_write = 0;
      seen = 0;
      for (int k = 0; k < 12 && !seen; k++) begin
         if (b_valid === 1'b1) seen = 1;
         else step();
      end
      checks++; if (!seen) $display("FAIL mid_rerun: no data_valid within 12 cycles"); else passes++;
      checks++; if (b_dout !== 4'hF) $display("FAIL mid_rerun_dout: got %h want f", b_dout); else passes++;
      checks++; if (b_cnt !== 16'd1) $display("FAIL mid_rerun_cnt: got %0d want 1", b_cnt); else passes++;
   endtask

   initial begin
      idle_inputs();
      ap_rst = 1'b1;
      test_reset();
      test_latency();
      test_two_words();
      test_run(64, 1'b0);
      test_run(63, 1'b1);
      test_errors();
      test_back_to_back_full();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/kernel_out_sink.md
KERNEL_OUT_SINK -- requirements
Module: kernel_out_sink

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the kernel result word; fixed at 32 in this revision.
REQ-002 Parameter FIFO_DEPTH, default 4: number of entries in the input buffer; must be a power of two, at least 2.
REQ-003 Parameter DRAIN_INV, default 1: pop one word every DRAIN_INV cycles; must be at least 1.
REQ-004 Parameter EXPECTED_WORDS, default 64: number of result words expected per kernel run.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 ap_clk  in  1  sole clock.
REQ-007 ap_rst  in  1  asynchronous, active-high reset.
REQ-008 ap_start  in  1  kernel start level.
REQ-009 ap_done  in  1  kernel completion pulse.
REQ-010 s_din  in  32  kernel result word (ap_fifo style).
REQ-011 s_write  in  1  write strobe for s_din.
REQ-012 s_full_n  out  1  high when a write is accepted this cycle.
REQ-013 data_out  out  4  folded result nibble.
REQ-014 data_valid  out  1  data_out is qualified.
REQ-015 word_cnt  out  16  words popped in the current run.
REQ-016 checksum  out  32  order-sensitive run checksum.
REQ-017 run_err  out  1  sticky run error flag.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, FLUSH, DONE.
- IDLE->RUN on an ap_start rising edge; the same edge clears word_cnt, checksum and run_err.
- RUN->FLUSH on ap_done.
- FLUSH->DONE when the FIFO is empty.
- DONE->IDLE unconditionally after 1 cycle.
REQ-019 s_full_n SHALL equal (count < FIFO_DEPTH), computed from registered state.
- A push is accepted iff s_write & s_full_n.
- A pop in the same cycle SHALL NOT free space for that cycle's push.
REQ-020 s_write while s_full_n=0 SHALL drop the word and set run_err; s_write in IDLE or DONE SHALL likewise drop the word and set run_err.
REQ-021 Pops SHALL occur only when the FIFO is non-empty and the drain counter reaches DRAIN_INV-1; the drain counter is free-running modulo DRAIN_INV.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
REQ-022 Fold on pop:
- x8 = w[7:0]^w[15:8]^w[23:16]^w[31:24]
- nibble = x8[7:4]^x8[3:0]
- The nibble is registered to data_out with data_valid=1 on the next cycle.
- data_out SHALL be 0 whenever data_valid=0.
REQ-023 Latency: a word pushed into an empty FIFO at cycle N with DRAIN_INV=1 SHALL appear on data_out at cycle N+2.
REQ-024 On each pop, word_cnt SHALL increment, saturating at 16'hFFFF.
REQ-025 On entering DONE, run_err SHALL be set if word_cnt != EXPECTED_WORDS.
REQ-026 ap_start rising while in RUN or FLUSH SHALL set run_err and be otherwise ignored.

Reset
REQ-027 On ap_rst, all of the following SHALL clear asynchronously:
- FSM to IDLE
- FIFO pointers and count to 0
- drain counter to 0
- outputs data_out=0, data_valid=0, word_cnt=0, checksum=0, run_err=0
REQ-028 s_full_n SHALL be 1 during reset.
REQ-029 Reset mid-run SHALL discard buffered words with no further data_valid pulses.

Configuration
REQ-030 Macro OUT_SINK_CHECKSUM_EN.
- Defined: on each pop, checksum <= {checksum[30:0],checksum[31]} ^ word.
- Undefined: checksum is tied to 0 and the checksum register is not built.

Structure
REQ-031 The shared package SHALL hold:
- FSM state encoding
- DATA_WIDTH
- the CLOG2 helper for pointer widths
REQ-032 One sub-module, out_sink_fifo (synchronous FIFO with count, full and empty), SHALL be used; the FSM, fold and checksum logic live at top level.

Verification
REQ-033 Start, then push 0x12345678 at cycle N into an empty FIFO with DRAIN_INV=1 -> data_valid=1 and data_out=4'h8 at N+2; checksum=0x12345678.
REQ-034 Push 0x12345678 then 0xFFFFFFFF -> data_out 8 then 0; checksum=0xDB97530F; word_cnt=2.
REQ-035 DRAIN_INV=4, FIFO_DEPTH=4, continuous s_write -> s_full_n falls after 4 accepted words; a forced write while full sets run_err=1.
REQ-036 Full run of 64 words then ap_done -> FLUSH drains, DONE is reached with run_err=0; the same test with 63 words -> run_err=1.
REQ-037 Assert ap_rst with 3 words buffered -> data_valid stays 0, s_full_n=1, all counters 0; a new run behaves normally.
REQ-038 Build without OUT_SINK_CHECKSUM_EN -> checksum stays 0; data_out and word_cnt are unchanged versus the REQ-034 results.
